tdm_1_4_demux: RTL and testbench

TDM_1_4_DEMUX -- requirements
Module: tdm_1_4_demux

---
 rtl/tdm_1_4_demux_if.sv | 26 ++
 rtl/tdm_1_4_demux.sv | 66 ++++++
 tb/tb_tdm_1_4_demux.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/tdm_1_4_demux_if.sv
// Sample/frame bus of the 1:4 TDM demultiplexer.
// The slave modport is the demux side; the master modport is the producer/consumer side.
interface tdm_1_4_demux_if #(
    parameter int WIDTH = 1
);
    logic             flush;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_a;
    logic [WIDTH-1:0] out_b;
    logic [WIDTH-1:0] out_c;
    logic [WIDTH-1:0] out_d;
    logic             out_valid;
    logic             out_ready;

    modport slave (
        input  flush, in_data, in_valid, out_ready,
        output in_ready, out_a, out_b, out_c, out_d, out_valid
    );

    modport master (
        output flush, in_data, in_valid, out_ready,
        input  in_ready, out_a, out_b, out_c, out_d, out_valid
    );
endinterface

// File: rtl/tdm_1_4_demux.sv
// 1:4 time-division demultiplexer: four accepted serial samples form one frame on out_a..out_d.
// Defining TDM_1_4_DEMUX_SLOT_PORT_EN exposes the slot counter on port slot.
module tdm_1_4_demux #(
    parameter int WIDTH = 1
) (
    input  logic       clk,
    input  logic       rst_n,
`ifdef TDM_1_4_DEMUX_SLOT_PORT_EN
    output logic [1:0] slot,
`endif
    tdm_1_4_demux_if.slave bus
);
    logic [1:0]       slot_p0;
    logic [WIDTH-1:0] a_p1;
    logic [WIDTH-1:0] b_p1;
    logic [WIDTH-1:0] c_p1;
    logic [WIDTH-1:0] d_p1;
    logic             vld_p1;
    logic             in_ready;
    logic             accept;

    // A held frame blocks intake unless the consumer takes it this very cycle.
    assign in_ready = !vld_p1 || bus.out_ready;
    assign accept   = bus.in_valid && in_ready;

    // Stage p0 -> p1: slot steering into the frame registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_p0 <= 2'd0;
            vld_p1  <= 1'b0;
            a_p1    <= '0;
            b_p1    <= '0;
            c_p1    <= '0;
            d_p1    <= '0;
        end else if (bus.flush) begin
            // Abort drops the partial frame position but keeps the frame data.
            slot_p0 <= 2'd0;
            vld_p1  <= 1'b0;
        end else begin
            if (accept) begin
                case (slot_p0)
                    2'd0:    a_p1 <= bus.in_data;
                    2'd1:    b_p1 <= bus.in_data;
                    2'd2:    c_p1 <= bus.in_data;
                    default: d_p1 <= bus.in_data;
                endcase
                slot_p0 <= slot_p0 + 2'd1;
            end
            if (accept && (slot_p0 == 2'd3)) begin
                vld_p1 <= 1'b1;
            end else if (vld_p1 && bus.out_ready) begin
                vld_p1 <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_a     = a_p1;
    assign bus.out_b     = b_p1;
    assign bus.out_c     = c_p1;
    assign bus.out_d     = d_p1;
    assign bus.out_valid = vld_p1;
`ifdef TDM_1_4_DEMUX_SLOT_PORT_EN
    assign slot = slot_p0;
`endif
endmodule

// File: tb/tb_tdm_1_4_demux.sv
// Directed bench for tdm_1_4_demux with WIDTH=1; frame shown as {out_a,out_b,out_c,out_d}.
// Slot port checks are compiled in when TDM_1_4_DEMUX_SLOT_PORT_EN is defined.
module tb_tdm_1_4_demux;
    localparam int W = 1;

    logic clk;
    logic rst_n;
    int   chk_cnt;
    int   err_cnt;
`ifdef TDM_1_4_DEMUX_SLOT_PORT_EN
    logic [1:0] slot;
`endif

    tdm_1_4_demux_if #(.WIDTH(W)) bus ();

    tdm_1_4_demux #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
`ifdef TDM_1_4_DEMUX_SLOT_PORT_EN
        .slot  (slot),
`endif
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] frame();
        return {bus.out_a, bus.out_b, bus.out_c, bus.out_d};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic v);
        bus.in_valid = 1'b1;
        bus.in_data  = v;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic check_slot(input string tag, input logic [1:0] exp);
`ifdef TDM_1_4_DEMUX_SLOT_PORT_EN
        check(tag, {30'd0, slot}, {30'd0, exp});
`endif
    endtask

    logic [11:0] stream;

    initial begin
        chk_cnt       = 0;
        err_cnt       = 0;
        rst_n         = 1'b0;
        bus.flush     = 1'b0;
        bus.in_data   = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;

        // Reset state
        #3;
        check("rst_valid", bus.out_valid, 0);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_frame", frame(), 4'b0000);
        tick();
        tick();
        rst_n = 1'b1;
        check("post_rst_in_ready", bus.in_ready, 1);
        check_slot("post_rst_slot", 2'd0);

        // Fill one frame 1,0,1,1 with the consumer stalled
        push(1'b1); check_slot("fill_slot1", 2'd1);
        push(1'b0); check_slot("fill_slot2", 2'd2);
        push(1'b1); check_slot("fill_slot3", 2'd3);
        check("fill_valid_early", bus.out_valid, 0);
        push(1'b1); check_slot("fill_slot0", 2'd0);
        check("fill_valid", bus.out_valid, 1);
        check("fill_frame", frame(), 4'b1011);
        check("fill_in_ready", bus.in_ready, 0);

        // Held frame under backpressure with a pending sample
        bus.in_valid = 1'b1;
        bus.in_data  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_frame", frame(), 4'b1011);
            check("hold_valid", bus.out_valid, 1);
            check_slot("hold_slot", 2'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        check("release_in_ready", bus.in_ready, 1);
        tick();
        check("release_valid", bus.out_valid, 0);
        check("release_frame", frame(), 4'b1011);

        // Streaming: 12 back-to-back samples, frames 0100, 0010, 1110
        stream = 12'b0100_0010_1110;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            bus.in_data = stream[11-i];
            check("stream_in_ready", bus.in_ready, 1);
            tick();
            check("stream_valid", bus.out_valid, (i % 4 == 3) ? 1 : 0);
            check_slot("stream_slot", 2'((i + 1) % 4));
            if (i % 4 == 3)
                check("stream_frame", frame(), 32'(stream[11-(i-3) -: 4]));
        end
        bus.in_valid = 1'b0;
        tick();
        check("stream_drain_valid", bus.out_valid, 0);

        // Flush mid-frame drops the concurrent sample and rewinds to slot 0
        bus.out_ready = 1'b0;
        push(1'b0);
        push(1'b0);
        check("pre_flush_frame", frame(), 4'b0010);
        bus.flush    = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 1'b0;
        tick();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        check("flush_valid", bus.out_valid, 0);
        check("flush_frame", frame(), 4'b0010);
        check_slot("flush_slot", 2'd0);
        push(1'b1);
        check("after_flush_frame", frame(), 4'b1010);
        push(1'b0);
        push(1'b1);
        check("after_flush_valid_early", bus.out_valid, 0);
        push(1'b1);
        check("after_flush_valid", bus.out_valid, 1);
        check("after_flush_frame_full", frame(), 4'b1011);

        // Flush also clears a held frame's valid without touching data
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        check("flush_held_valid", bus.out_valid, 0);
        check("flush_held_frame", frame(), 4'b1011);

        // Asynchronous reset between edges after 3 accepts
        push(1'b1);
        push(1'b1);
        push(1'b1);
        check("pre_rst_frame", frame(), 4'b1111);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_frame", frame(), 4'b0000);
        check("async_rst_valid", bus.out_valid, 0);
        check("async_rst_in_ready", bus.in_ready, 1);
        check_slot("async_rst_slot", 2'd0);
        rst_n = 1'b1;
        tick();
        check("post_async_frame", frame(), 4'b0000);
        push(1'b0);
        push(1'b1);
        push(1'b0);
        push(1'b1);
        check("new_frame", frame(), 4'b0101);
        check("new_frame_valid", bus.out_valid, 1);

        $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
        $finish;
    end
endmodule
